// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes on both sides and registered results.
// Logic ops finish in one cycle; MUL (shift-add) and DIVU/REMU (restoring) take WIDTH iterations.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  logic [1:0]       state_q,  state_d;
  logic [SHW-1:0]   cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic             mul_q,    mul_d;
  logic             rem_q,    rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;

  logic [WIDTH-1:0] alu_c;
  logic [SHW-1:0]   shamt_c;
  logic             multi_c;
  logic [WIDTH-1:0] mul_acc_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   diff_c;
  logic             no_borrow_c;
  logic [WIDTH-1:0] div_rem_c;
  logic [WIDTH-1:0] div_quo_c;
  logic [WIDTH-1:0] final_c;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign zero      = zero_q;

  // Single-cycle datapath; DIVU/REMU entries only matter for the divide-by-zero shortcut
  always_comb begin
    shamt_c = op2[SHW-1:0];
    alu_c   = '0;
    case (alu_op)
      OP_AND:  alu_c = op1 & op2;
      OP_OR:   alu_c = op1 | op2;
      OP_ADD:  alu_c = op1 + op2;
      OP_SUB:  alu_c = op1 - op2;
      OP_SLT:  alu_c = WIDTH'($signed(op1) < $signed(op2));
      OP_SLTU: alu_c = WIDTH'(op1 < op2);
      OP_XOR:  alu_c = op1 ^ op2;
      OP_SRL:  alu_c = op1 >> shamt_c;
      OP_SLL:  alu_c = op1 << shamt_c;
      OP_SRA:  alu_c = WIDTH'($signed(op1) >>> shamt_c);
      OP_DIVU: alu_c = '1;
      OP_REMU: alu_c = op1;
      default: alu_c = '0;
    endcase
  end

  assign multi_c = (alu_op == OP_MUL) ||
                   (((alu_op == OP_DIVU) || (alu_op == OP_REMU)) && (op2 != '0));

  // One iteration: multiply adds the shifted multiplicand; divide is a restoring step
  always_comb begin
    mul_acc_c   = acc_q + (b_q[0] ? a_q : '0);
    trial_c     = {acc_q, a_q[WIDTH-1]};
    diff_c      = trial_c - {1'b0, b_q};
    no_borrow_c = ~diff_c[WIDTH];
    div_rem_c   = no_borrow_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
    div_quo_c   = {a_q[WIDTH-2:0], no_borrow_c};
    if (mul_q) begin
      final_c = mul_acc_c;
    end else begin
      final_c = rem_q ? div_rem_c : div_quo_c;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    mul_d    = mul_q;
    rem_d    = rem_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (multi_c) begin
            state_d = S_BUSY;
            cnt_d   = SHW'(WIDTH - 1);
            acc_d   = '0;
            a_d     = op1;
            b_d     = op2;
            mul_d   = (alu_op == OP_MUL);
            rem_d   = (alu_op == OP_REMU);
          end else begin
            state_d  = S_DONE;
            result_d = alu_c;
            zero_d   = (alu_c == '0);
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - SHW'(1);
        if (mul_q) begin
          acc_d = mul_acc_c;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = div_rem_c;
          a_d   = div_quo_c;
        end
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = final_c;
          zero_d   = (final_c == '0);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mul_q    <= 1'b0;
      rem_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mul_q    <= mul_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule
